// File: rtl/rx_wr_arbiter.sv
// Four per-channel write FIFOs drained round-robin into one registered memory write port.
// Optional per-channel 16-bit drop counters are compiled in with RXARB_DROPCNT_EN.
module rx_wr_arbiter #(
  parameter int DW     = 12,
  parameter int AW     = 16,
  parameter int FDEPTH = 4
) (
  input  logic              Cclk,
  input  logic              rstn,
  input  logic [3:0]        WrEn,
  input  logic [4*AW-1:0]   WrAdd,
  input  logic [4*DW-1:0]   WrData,
  input  logic [3:0]        Out_Off_Link,
  input  logic              ClrOvf,
  output logic              MemWe,
  output logic [1:0]        MemCh,
  output logic [AW-1:0]     MemAdd,
  output logic [DW-1:0]     MemData,
  output logic [3:0]        Ovf,
  output logic [4*16-1:0]   DropCnt
);

  localparam int IW = $clog2(FDEPTH);
  localparam int PW = IW + 1;
  localparam int EW = AW + DW;

  logic [EW-1:0] fifoMem [4][FDEPTH];
  logic [PW-1:0] wrPtr   [4];
  logic [PW-1:0] rdPtr   [4];

  logic [3:0]    empty, full, cand, push, pop, drop;
  logic          grantVld;
  logic [1:0]    grantCh;
  logic [1:0]    last;
  logic [EW-1:0] head;

  // The extra pointer MSB tells full from empty when the index bits match.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      empty[i] = (wrPtr[i] == rdPtr[i]);
      full[i]  = (wrPtr[i][IW] != rdPtr[i][IW]) &&
                 (wrPtr[i][IW-1:0] == rdPtr[i][IW-1:0]);
      cand[i]  = !empty[i] && !Out_Off_Link[i];
    end
  end

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    logic [1:0] idx;
    // NOTE: combinational outputs get a default before any branch so no latch is inferred.
    grantVld = 1'b0;
    grantCh  = last;
    idx      = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!grantVld && cand[idx]) begin
        grantVld = 1'b1;
        grantCh  = idx;
      end
    end
  end

  // A pop on a full FIFO frees the slot that the same-cycle push lands in.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pop[i]  = grantVld && (grantCh == 2'(i));
      push[i] = WrEn[i] && !Out_Off_Link[i] && (!full[i] || pop[i]);
      drop[i] = WrEn[i] && !Out_Off_Link[i] && full[i] && !pop[i];
    end
  end

  assign head = fifoMem[grantCh][rdPtr[grantCh][IW-1:0]];

  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 4; i++) begin
        wrPtr[i] <= '0;
        rdPtr[i] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
      for (int i = 0; i < 4; i++) begin
        if (push[i])
          wrPtr[i] <= wrPtr[i] + PW'(1);
        if (Out_Off_Link[i])
          rdPtr[i] <= wrPtr[i];
        else if (pop[i])
          rdPtr[i] <= rdPtr[i] + PW'(1);
      end
    end
  end

  // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge Cclk) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i])
        fifoMem[i][wrPtr[i][IW-1:0]] <= {WrAdd[AW*i +: AW], WrData[DW*i +: DW]};
    end
  end

  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      MemWe   <= 1'b0;
      MemCh   <= '0;
      MemAdd  <= '0;
      MemData <= '0;
      last    <= 2'd3;
    end else begin
      MemWe <= grantVld;
      if (grantVld) begin
        MemCh   <= grantCh;
        MemAdd  <= head[EW-1:DW];
        MemData <= head[DW-1:0];
        last    <= grantCh;
      end
    end
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      Ovf <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (drop[i])
          Ovf[i] <= 1'b1;
        else if (ClrOvf)
          Ovf[i] <= 1'b0;
      end
    end
  end

`ifdef RXARB_DROPCNT_EN
  logic [15:0] dropCnt [4];

  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 4; i++)
        dropCnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (drop[i]) begin
          if (ClrOvf)
            dropCnt[i] <= 16'd1;
          else if (dropCnt[i] != 16'hFFFF)
            dropCnt[i] <= dropCnt[i] + 16'd1;
        end else if (ClrOvf) begin
          dropCnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    DropCnt = '0;
    for (int i = 0; i < 4; i++)
      DropCnt[16*i +: 16] = dropCnt[i];
  end
`else
  assign DropCnt = '0;
`endif

endmodule

// File: tb/tb_rx_wr_arbiter.sv
// Self-checking bench for rx_wr_arbiter: queue-based reference model feeds a scoreboard
// that a negedge monitor drains whenever the memory port is (or should be) written.
module tb_rx_wr_arbiter;

  localparam int DW     = 12;
  localparam int AW     = 16;
  localparam int FDEPTH = 4;
  localparam int EW     = AW + DW;

  logic              Cclk;
  logic              rstn;
  logic [3:0]        WrEn;
  logic [4*AW-1:0]   WrAdd;
  logic [4*DW-1:0]   WrData;
  logic [3:0]        Out_Off_Link;
  logic              ClrOvf;
  logic              MemWe;
  logic [1:0]        MemCh;
  logic [AW-1:0]     MemAdd;
  logic [DW-1:0]     MemData;
  logic [3:0]        Ovf;
  logic [4*16-1:0]   DropCnt;

  rx_wr_arbiter #(.DW(DW), .AW(AW), .FDEPTH(FDEPTH)) dut (
    .Cclk         (Cclk),
    .rstn         (rstn),
    .WrEn         (WrEn),
    .WrAdd        (WrAdd),
    .WrData       (WrData),
    .Out_Off_Link (Out_Off_Link),
    .ClrOvf       (ClrOvf),
    .MemWe        (MemWe),
    .MemCh        (MemCh),
    .MemAdd       (MemAdd),
    .MemData      (MemData),
    .Ovf          (Ovf),
    .DropCnt      (DropCnt)
  );

  initial Cclk = 1'b0;
  always #5 Cclk = ~Cclk;

  typedef struct {
    int            cyc;
    logic [1:0]    ch;
    logic [AW-1:0] add;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [EW-1:0] mq[4][$];
  int            mLast;
  logic [3:0]    mOvf;
  int            mCnt[4];
  int            cyc;
  int            checks;
  int            errors;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mq[i].delete();
      mCnt[i] = 0;
    end
    mLast = 3;
    mOvf  = '0;
    sb.delete();
  endtask

  // One clock edge: the model applies the stated rules to the inputs present at the edge.
  task automatic tick();
    int            g;
    logic [EW-1:0] ent;
    exp_t          e;
    logic          dropped;
    logic [63:0]   expCnt;
    @(posedge Cclk);
    cyc++;
    g = -1;
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (mLast + k) % 4;
      if (g < 0 && mq[c].size() > 0 && !Out_Off_Link[c]) g = c;
    end
    if (g >= 0) begin
      ent    = mq[g].pop_front();
      e.cyc  = cyc;
      e.ch   = 2'(g);
      e.add  = ent[EW-1:DW];
      e.data = ent[DW-1:0];
      sb.push_back(e);
      mLast  = g;
    end
    for (int i = 0; i < 4; i++) begin
      dropped = 1'b0;
      if (Out_Off_Link[i])
        mq[i].delete();
      else if (WrEn[i]) begin
        if (mq[i].size() < FDEPTH)
          mq[i].push_back({WrAdd[AW*i +: AW], WrData[DW*i +: DW]});
        else
          dropped = 1'b1;
      end
      if (dropped) begin
        mOvf[i] = 1'b1;
        if (ClrOvf) mCnt[i] = 1;
        else if (mCnt[i] < 65535) mCnt[i]++;
      end else if (ClrOvf) begin
        mOvf[i] = 1'b0;
        mCnt[i] = 0;
      end
    end
    #1;
    check("ovf", 64'(Ovf), 64'(mOvf));
    expCnt = '0;
`ifdef RXARB_DROPCNT_EN
    for (int i = 0; i < 4; i++) expCnt[16*i +: 16] = 16'(mCnt[i]);
`endif
    check("dropcnt", DropCnt, expCnt);
  endtask

  task automatic drive(input logic [3:0] en, input logic [3:0] ool, input logic clr);
    WrEn         = en;
    Out_Off_Link = ool;
    ClrOvf       = clr;
    for (int i = 0; i < 4; i++) begin
      WrAdd[AW*i +: AW]  = AW'($urandom);
      WrData[DW*i +: DW] = DW'($urandom);
    end
  endtask

  // Monitor: any write must match the oldest expectation, and due expectations must appear.
  always @(negedge Cclk) begin
    if (rstn) begin
      logic due;
      exp_t e;
      due = (sb.size() > 0) && (sb[0].cyc <= cyc);
      check("mem_we", 64'(MemWe), 64'(due));
      if (sb.size() > 0 && (MemWe || due)) begin
        e = sb.pop_front();
        if (MemWe) begin
          check("wr_cycle", 64'(cyc), 64'(e.cyc));
          check("wr_ch", 64'(MemCh), 64'(e.ch));
          check("wr_add", 64'(MemAdd), 64'(e.add));
          check("wr_data", 64'(MemData), 64'(e.data));
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    rstn   = 1'b0;
    drive(4'h0, 4'h0, 1'b0);
    model_reset();
    repeat (2) @(posedge Cclk);
    #3 rstn = 1'b1;
    check("rst_memwe", 64'(MemWe), 64'd0);
    check("rst_memch", 64'(MemCh), 64'd0);
    check("rst_memadd", 64'(MemAdd), 64'd0);
    check("rst_memdata", 64'(MemData), 64'd0);

    // Idle after reset.
    repeat (20) tick();

    // Single write on channel 2.
    drive(4'b0100, 4'h0, 1'b0);
    WrAdd[AW*2 +: AW]  = 16'h1234;
    WrData[DW*2 +: DW] = 12'hABC;
    tick();
    drive(4'h0, 4'h0, 1'b0);
    repeat (4) tick();

    // Round-robin bursts, twice.
    for (int r = 0; r < 2; r++) begin
      drive(4'hF, 4'h0, 1'b0);
      for (int i = 0; i < 4; i++) WrAdd[AW*i +: AW] = AW'(16'h0100 * (i + 1) + r);
      tick();
      drive(4'h0, 4'h0, 1'b0);
      repeat (6) tick();
    end

    // Overflow on channel 1 while channel 0 also streams, then clear.
    for (int n = 0; n < 10; n++) begin
      drive(4'b0011, 4'h0, 1'b0);
      tick();
    end
    drive(4'h0, 4'h0, 1'b0);
    repeat (8) tick();
    drive(4'h0, 4'h0, 1'b1);
    tick();
    drive(4'h0, 4'h0, 1'b0);
    repeat (2) tick();

    // Flush channel 3 while its requests continue during the pulse.
    for (int n = 0; n < 3; n++) begin
      drive(4'hF, 4'h0, 1'b0);
      tick();
    end
    for (int n = 0; n < 2; n++) begin
      drive(4'hF, 4'b1000, 1'b0);
      tick();
    end
    drive(4'h0, 4'h0, 1'b0);
    repeat (10) tick();

    // Randomized traffic with occasional link loss and clears.
    for (int n = 0; n < 400; n++) begin
      logic [3:0] en, ool;
      for (int i = 0; i < 4; i++) begin
        en[i]  = ($urandom_range(0, 99) < 30);
        ool[i] = ($urandom_range(0, 99) < 4);
      end
      drive(en, ool, $urandom_range(0, 99) < 3);
      tick();
    end
    drive(4'h0, 4'h0, 1'b0);
    repeat (10) tick();

    // Asynchronous reset while all FIFOs hold entries.
    drive(4'hF, 4'h0, 1'b0);
    tick();
    tick();
    drive(4'h0, 4'h0, 1'b0);
    #2 rstn = 1'b0;
    model_reset();
    #1;
    check("async_rst_memwe", 64'(MemWe), 64'd0);
    check("async_rst_ovf", 64'(Ovf), 64'd0);
    repeat (2) @(posedge Cclk);
    #3 rstn = 1'b1;
    repeat (10) tick();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL pending_writes: got %0d outstanding expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_wr_arbiter.md
# rx_wr_arbiter

Shares a single memory write port between the four per-channel receive write streams in the Rx path. Each stream's write enable, address and data are absorbed into a small per-channel FIFO, and a round-robin arbiter drains one entry per cycle into a registered write port. The block sits between the four per-channel data collectors and a single channel-banked line memory. It also reports per-channel overflow and flushes a channel that goes out of link.

## Interface
- DW, 12, write data width per channel
- AW, 16, write address width per channel
- FDEPTH, 4, per-channel FIFO depth; power of two, ≥2
- Cclk  in  1  system clock; all logic is on the rising edge
- rstn  in  1  asynchronous, active-low reset
- WrEn  in  4  per-channel write request, one bit per channel
- WrAdd  in  4*AW  per-channel write address; channel i at [AW*i+AW-1:AW*i]
- WrData  in  4*DW  per-channel write data; channel i at [DW*i+DW-1:DW*i]
- Out_Off_Link  in  4  per-channel flush/disable, level-sensitive
- ClrOvf  in  1  single-cycle pulse; clears Ovf and DropCnt
- MemWe  out  1  registered write strobe to the shared memory
- MemCh  out  2  channel (bank) index of the current write
- MemAdd  out  AW  write address
- MemData  out  DW  write data
- Ovf  out  4  sticky per-channel overflow flag
- DropCnt  out  4*16  per-channel drop counters; channel i at [16*i+15:16*i]

## Operation
- Per-channel FIFO: FDEPTH entries of {AW,DW}, with read/write pointers one bit wider than the index.
  - Push when WrEn[i] && !full_i && !Out_Off_Link[i].
  - If WrEn[i] && full_i, the sample is dropped and Ovf[i] is set.
- Simultaneous push and pop on a full FIFO: the pop frees a slot, so the push is accepted with no drop.
- Out_Off_Link[i] high:
  - FIFO i is flushed (rd_ptr <= wr_ptr) every cycle it is high.
  - Pushes from channel i are ignored and are not counted as drops.
  - Channel i is excluded from arbitration.
- Arbiter: round-robin with a 2-bit last-grant pointer `last`.
  - Candidates are channels with a non-empty FIFO and Out_Off_Link low.
  - Search order is last+1, last+2, last+3, last, all mod 4.
  - The first candidate is granted, its FIFO is popped, and `last` is updated to it.
  - With no candidate, `last` holds and there is no grant.
- Output register: on a grant, MemWe <= 1, MemCh <= grant, and MemAdd/MemData <= the FIFO head. Otherwise MemWe <= 0 and MemCh/MemAdd/MemData hold.
- Ovf[i] clears on ClrOvf. If ClrOvf and a new drop occur in the same cycle, the drop wins and Ovf[i] stays 1.
- Throughput: at most one write per cycle. The aggregate sustained WrEn rate must be ≤1 per cycle; bursts up to FDEPTH per channel are lossless.

## Timing
- Reset values: MemWe=0, MemCh=0, MemAdd=0, MemData=0, Ovf=0, DropCnt=0, all FIFOs empty, last=3 (channel 0 is first in priority).
- Latency: WrEn sampled at edge t into an empty FIFO gives MemWe=1 after edge t+1 at the earliest (one FIFO stage plus the output register). There is no combinational path from WrEn to Mem*.
- Grant is combinational from FIFO non-empty and Out_Off_Link, both registered or input-level.
- Asserting Out_Off_Link[i] in the same cycle as a grant to channel i: the grant is suppressed and MemWe is 0 for that slot.
- Reset mid-operation: all FIFO contents are discarded and the outputs take their reset values immediately, because reset is asynchronous.
- Fairness: with all four channels continuously non-empty, the grant sequence is 0,1,2,3,0,… and each channel gets exactly one write per 4 cycles.

## Configuration
- RXARB_DROPCNT_EN defined:
  - Per-channel 16-bit drop counter increments on each dropped sample.
  - The counter saturates at 16'hFFFF.
  - ClrOvf clears it; a drop in the same cycle as ClrOvf loads 1.
- Not defined: DropCnt is tied to 0, and Ovf behaviour is unchanged.

## Test plan
- Reset check: after reset release with no WrEn, MemWe=0, Ovf=4'h0 and DropCnt=0 for 20 cycles.
- Single write and latency: one pulse WrEn=4'b0100, WrAdd ch2=16'h1234, WrData ch2=12'hABC at edge t. MemWe=1 follows after edge t+1 with MemCh=2, MemAdd=16'h1234, MemData=12'hABC, then MemWe=0.
- Round-robin: WrEn=4'hF for 1 cycle with distinct addresses. Four consecutive writes follow in channel order 0,1,2,3. Repeat the burst: the order is again 0,1,2,3 because last=3.
- Overflow: FDEPTH=4, ch1 WrEn held 10 cycles while ch0 WrEn is also held continuously. Ovf[1]=1, and with RXARB_DROPCNT_EN DropCnt ch1 equals the accepted-vs-offered difference. After a ClrOvf pulse, Ovf=0 and DropCnt=0.
- Flush: fill ch3 with 3 entries while blocking service by keeping ch0–ch2 busy, then pulse Out_Off_Link[3]. No ch3 write appears afterwards, and ch3 WrEn during the pulse sets neither Ovf[3] nor DropCnt.
- Reset mid-burst: assert rstn=0 while all FIFOs are non-empty. MemWe drops to 0 asynchronously, and no stale entry is written after release.
